sine_voice_scheduler: RTL and testbench

Time-multiplexes one shared sine-ROM read port across all phase-accumulator voices and sums their outputs into a single mixed sample. On each sample tick it sweeps every voice in index order: it issues the ROM address from that voice's phase, retires the ROM data after the fixed ROM latency, and accumulates only gated voices. It sits between the 24-voice phase accumulator bank and the audio output/PDM stage. It also emits the per-sample advance strobe that steps the accumulators.

---
 rtl/synth_pkg.sv | 16 +
 rtl/sine_voice_scheduler_tag_delay_line.sv | 41 ++++
 rtl/sine_voice_scheduler.sv | 135 +++++++++++++
 tb/tb_sine_voice_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and FSM state type for the sine voice scheduler and its helpers.
package synth_pkg;

    localparam int NUM_VOICES  = 24;
    localparam int ROM_LATENCY = 2;
    localparam int PHASE_W     = 32;
    localparam int SAMPLE_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sine_voice_scheduler_tag_delay_line.sv
// Shift register of {valid, gated} tags that tracks each ROM read through the ROM pipeline.
module tag_delay_line #(
    parameter int DEPTH = synth_pkg::ROM_LATENCY
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic push_valid_in,
    input  logic push_gated_in,
    output logic pop_valid_out,
    output logic pop_gated_out
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] gated_q, gated_d;

    always_comb begin
        valid_d[0] = push_valid_in;
        gated_d[0] = push_gated_in;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            gated_d[i] = gated_q[i-1];
        end
    end

    // NOTE: unlike a data RAM these stages must be reset; a stale valid bit
    // would retire garbage into the first sweep after reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            gated_q <= '0;
        end else begin
            // NOTE: non-blocking so every stage shifts from its pre-edge value.
            valid_q <= valid_d;
            gated_q <= gated_d;
        end
    end

    assign pop_valid_out = valid_q[DEPTH-1];
    assign pop_gated_out = gated_q[DEPTH-1];

endmodule

// File: rtl/sine_voice_scheduler.sv
// Sweeps all voices through one shared sine ROM per sample tick and sums the gated outputs.
module sine_voice_scheduler #(
    parameter int NUM_VOICES  = synth_pkg::NUM_VOICES,
    parameter int PHASE_W     = synth_pkg::PHASE_W,
    parameter int ADDR_W      = 8,
    parameter int SAMPLE_W    = synth_pkg::SAMPLE_W,
    parameter int ROM_LATENCY = synth_pkg::ROM_LATENCY,
    parameter int OUT_W       = SAMPLE_W + $clog2(NUM_VOICES)
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       sample_tick_in,
    input  logic [NUM_VOICES-1:0]      gate_in,
    input  logic [PHASE_W-1:0]         phase_in [NUM_VOICES],
    output logic [ADDR_W-1:0]          rom_addr_out,
    input  logic signed [SAMPLE_W-1:0] rom_data_in,
    output logic signed [OUT_W-1:0]    mix_out,
    output logic                       mix_valid_out,
    output logic                       advance_out,
    output logic                       busy_out,
    output logic                       overrun_out
);

    import synth_pkg::*;

    localparam int VIDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DRAIN_W = $clog2(ROM_LATENCY + 1);

    sched_state_t               state_q, state_d;
    logic [VIDX_W-1:0]          idx_q, idx_d;
    logic [DRAIN_W-1:0]         drain_q, drain_d;
    logic [NUM_VOICES-1:0]      gate_snap_q, gate_snap_d;
    logic signed [OUT_W-1:0]    acc_q, acc_d;
    logic signed [OUT_W-1:0]    mix_q, mix_d;
    logic                       overrun_q, overrun_d;

    logic tag_valid, tag_gated, push_valid, push_gated, retire;
    logic signed [OUT_W-1:0] rom_sext;
    logic phase_unused;

    assign push_valid = (state_q == ISSUE);
    assign push_gated = gate_snap_q[idx_q];

    tag_delay_line #(.DEPTH(ROM_LATENCY)) u_tag_line (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .push_valid_in (push_valid),
        .push_gated_in (push_gated),
        .pop_valid_out (tag_valid),
        .pop_gated_out (tag_gated)
    );

    assign rom_sext = {{(OUT_W-SAMPLE_W){rom_data_in[SAMPLE_W-1]}}, rom_data_in};
    assign retire   = tag_valid && tag_gated && (state_q == ISSUE || state_q == DRAIN);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no branch can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        gate_snap_d = gate_snap_q;
        acc_d       = acc_q;
        mix_d       = mix_q;
        overrun_d   = sample_tick_in && (state_q != IDLE);

        if (retire) acc_d = acc_q + rom_sext;

        case (state_q)
            IDLE: begin
                if (sample_tick_in) begin
                    gate_snap_d = gate_in;
                    acc_d       = '0;
                    idx_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                idx_d = idx_q + VIDX_W'(1);
                if (idx_q == VIDX_W'(NUM_VOICES - 1)) begin
                    idx_d   = '0;
                    drain_d = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                // The last retirement lands on this same edge, so publish acc_d.
                if (drain_q == DRAIN_W'(ROM_LATENCY - 1)) begin
                    mix_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            drain_q     <= '0;
            gate_snap_q <= '0;
            acc_q       <= '0;
            mix_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            gate_snap_q <= gate_snap_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        rom_addr_out = '0;
        if (state_q == ISSUE) rom_addr_out = phase_in[idx_q][PHASE_W-1 -: ADDR_W];
    end

    // Only the phase MSBs address the ROM; the fractional bits are deliberately dropped.
    always_comb begin
        phase_unused = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) phase_unused ^= ^phase_in[v][PHASE_W-ADDR_W-1:0];
    end

    assign mix_out       = mix_q;
    assign mix_valid_out = (state_q == DONE);
    assign advance_out   = (state_q == DONE);
    assign busy_out      = (state_q != IDLE);
    assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed testbench for sine_voice_scheduler with a 2-cycle ROM model and per-scenario checks.
module tb_sine_voice_scheduler;

    localparam int NV  = 24;
    localparam int OBS = 64;

    logic                clk_in = 1'b0;
    logic                rst_n_in = 1'b0;
    logic                sample_tick_in = 1'b0;
    logic [NV-1:0]       gate_in = '0;
    logic [31:0]         phase_in [NV];
    logic [7:0]          rom_addr_out;
    logic signed [15:0]  rom_data_in;
    logic signed [20:0]  mix_out;
    logic                mix_valid_out, advance_out, busy_out, overrun_out;

    int checks = 0;
    int failures = 0;

    int                 rom_mode = 0;
    logic signed [15:0] rom_const = '0;
    logic [7:0]         rom_p0 = '0;
    logic [7:0]         rom_p1 = '0;

    logic [7:0]         o_addr  [OBS];
    logic               o_valid [OBS];
    logic               o_adv   [OBS];
    logic               o_busy  [OBS];
    logic               o_ovr   [OBS];
    logic signed [20:0] o_mix   [OBS];

    sine_voice_scheduler dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .sample_tick_in (sample_tick_in),
        .gate_in        (gate_in),
        .phase_in       (phase_in),
        .rom_addr_out   (rom_addr_out),
        .rom_data_in    (rom_data_in),
        .mix_out        (mix_out),
        .mix_valid_out  (mix_valid_out),
        .advance_out    (advance_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    // ROM model: data appears two cycles after the address is presented.
    always @(posedge clk_in) begin
        rom_p0 <= rom_addr_out;
        rom_p1 <= rom_p0;
    end

    always_comb begin
        if (rom_mode == 0) rom_data_in = (rom_p1 == 8'h40) ? 16'sd1000 : 16'sd0;
        else               rom_data_in = rom_const;
    end

    function automatic logic [7:0] exp_addr(input int k);
        logic [7:0] a;
        a = 8'h80 + 8'(k);
        if (k == 5) a = 8'h40;
        return a;
    endfunction

    // Pulses a tick (sampled at edge T), then records outputs at the falling edge of cycles T+1..T+63.
    task automatic sweep_observe(input int tick2_cyc, input bit toggle_gate);
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        for (int c = 1; c < OBS; c++) begin
            if (c > 1) @(negedge clk_in);
            o_addr[c]  = rom_addr_out;
            o_valid[c] = mix_valid_out;
            o_adv[c]   = advance_out;
            o_busy[c]  = busy_out;
            o_ovr[c]   = overrun_out;
            o_mix[c]   = mix_out;
            sample_tick_in = (c == tick2_cyc);
            if (toggle_gate && c <= 24) gate_in = ~gate_in;
        end
        sample_tick_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({rom_addr_out, mix_out, mix_valid_out, advance_out, busy_out, overrun_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h mix=%0d valid=%b adv=%b busy=%b ovr=%b, expected all 0",
                     rom_addr_out, mix_out, mix_valid_out, advance_out, busy_out, overrun_out);
        end
        rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_single_voice();
        rom_mode = 0;
        gate_in  = NV'(1) << 5;
        sweep_observe(0, 1'b0);
        for (int c = 1; c <= 30; c++) begin
            logic [7:0] ea;
            ea = (c <= 24) ? exp_addr(c - 1) : 8'h00;
            checks++;
            if (o_addr[c] !== ea) begin
                failures++;
                $display("FAIL single_addr c%0d: got %h expected %h", c, o_addr[c], ea);
            end
            checks++;
            if (o_valid[c] !== (c == 27) || o_adv[c] !== (c == 27)) begin
                failures++;
                $display("FAIL single_pulses c%0d: got valid=%b adv=%b expected %b", c, o_valid[c], o_adv[c], c == 27);
            end
            checks++;
            if (o_busy[c] !== (c <= 27)) begin
                failures++;
                $display("FAIL single_busy c%0d: got %b expected %b", c, o_busy[c], c <= 27);
            end
        end
        checks++;
        if (o_mix[27] !== 21'sd1000) begin
            failures++;
            $display("FAIL single_mix: got %0d expected 1000", o_mix[27]);
        end
        checks++;
        if (o_mix[45] !== 21'sd1000) begin
            failures++;
            $display("FAIL single_mix_held: got %0d expected 1000", o_mix[45]);
        end
    endtask

    task automatic test_full_scale();
        rom_mode  = 1;
        gate_in   = '1;
        rom_const = 16'sd32767;
        sweep_observe(0, 1'b0);
        checks++;
        if (o_mix[27] !== 21'sd786408 || o_valid[27] !== 1'b1) begin
            failures++;
            $display("FAIL full_pos: got mix=%0d valid=%b expected 786408 valid=1", o_mix[27], o_valid[27]);
        end
        rom_const = -16'sd32768;
        sweep_observe(0, 1'b0);
        checks++;
        if (o_mix[26] !== 21'sd786408) begin
            failures++;
            $display("FAIL full_held_before_done: got %0d expected 786408", o_mix[26]);
        end
        checks++;
        if (o_mix[27] !== -21'sd786432) begin
            failures++;
            $display("FAIL full_neg: got %0d expected -786432", o_mix[27]);
        end
    endtask

    task automatic test_gating();
        int nvalid;
        rom_mode  = 1;
        rom_const = 16'sd1234;
        gate_in   = '0;
        sweep_observe(0, 1'b0);
        nvalid = 0;
        for (int c = 1; c < OBS; c++) if (o_valid[c] === 1'b1) nvalid++;
        checks++;
        if (o_mix[27] !== 21'sd0 || o_valid[27] !== 1'b1 || o_adv[27] !== 1'b1 || nvalid != 1) begin
            failures++;
            $display("FAIL ungated: got mix=%0d valid=%b adv=%b pulses=%0d expected 0 1 1 1",
                     o_mix[27], o_valid[27], o_adv[27], nvalid);
        end
        rom_const = 16'sd100;
        gate_in   = NV'(24'h00000F);
        sweep_observe(0, 1'b1);
        checks++;
        if (o_mix[27] !== 21'sd400) begin
            failures++;
            $display("FAIL gate_snapshot: got %0d expected 400", o_mix[27]);
        end
    endtask

    task automatic test_overrun();
        int nvalid;
        rom_mode  = 1;
        rom_const = 16'sd1;
        gate_in   = '1;
        sweep_observe(10, 1'b0);
        for (int c = 1; c < OBS; c++) begin
            checks++;
            if (o_ovr[c] !== (c == 11)) begin
                failures++;
                $display("FAIL overrun c%0d: got %b expected %b", c, o_ovr[c], c == 11);
            end
        end
        nvalid = 0;
        for (int c = 1; c < OBS; c++) if (o_valid[c] === 1'b1) nvalid++;
        checks++;
        if (nvalid != 1 || o_valid[27] !== 1'b1 || o_busy[40] !== 1'b0) begin
            failures++;
            $display("FAIL overrun_single_sweep: got pulses=%0d valid27=%b busy40=%b expected 1 1 0",
                     nvalid, o_valid[27], o_busy[40]);
        end
        checks++;
        if (o_mix[27] !== 21'sd24) begin
            failures++;
            $display("FAIL overrun_mix: got %0d expected 24", o_mix[27]);
        end
    endtask

    task automatic test_back_to_back();
        int novr;
        rom_mode  = 1;
        rom_const = 16'sd2;
        gate_in   = '1;
        sweep_observe(28, 1'b0);
        novr = 0;
        for (int c = 1; c < OBS; c++) if (o_ovr[c] === 1'b1) novr++;
        checks++;
        if (novr != 0) begin
            failures++;
            $display("FAIL b2b_no_overrun: got %0d overrun pulses expected 0", novr);
        end
        checks++;
        if (o_valid[27] !== 1'b1 || o_valid[55] !== 1'b1 || o_adv[55] !== 1'b1 || o_valid[54] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pulses: got v27=%b v55=%b a55=%b v54=%b expected 1 1 1 0",
                     o_valid[27], o_valid[55], o_adv[55], o_valid[54]);
        end
        checks++;
        if (o_addr[28] !== 8'h00 || o_addr[29] !== exp_addr(0) || o_addr[34] !== exp_addr(5) || o_addr[52] !== exp_addr(23)) begin
            failures++;
            $display("FAIL b2b_addr_restart: got %h %h %h %h expected 00 %h %h %h",
                     o_addr[28], o_addr[29], o_addr[34], o_addr[52], exp_addr(0), exp_addr(5), exp_addr(23));
        end
        checks++;
        if (o_mix[27] !== 21'sd48 || o_mix[55] !== 21'sd48) begin
            failures++;
            $display("FAIL b2b_mix: got %0d and %0d expected 48 and 48", o_mix[27], o_mix[55]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int npulse;
        rom_mode  = 1;
        rom_const = 16'sd500;
        gate_in   = '1;
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        repeat (7) @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({rom_addr_out, mix_out, mix_valid_out, advance_out, busy_out, overrun_out} !== '0) begin
            failures++;
            $display("FAIL reset_mid_issue: got addr=%h mix=%0d valid=%b adv=%b busy=%b ovr=%b expected all 0",
                     rom_addr_out, mix_out, mix_valid_out, advance_out, busy_out, overrun_out);
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (mix_valid_out || advance_out || overrun_out || busy_out) npulse++;
        end
        checks++;
        if (npulse != 0) begin
            failures++;
            $display("FAIL reset_quiet: got %0d active cycles expected 0", npulse);
        end
        sweep_observe(0, 1'b0);
        checks++;
        if (o_mix[27] !== 21'sd12000 || o_valid[27] !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_tick: got mix=%0d valid=%b expected 12000 valid=1", o_mix[27], o_valid[27]);
        end
    endtask

    initial begin
        for (int i = 0; i < NV; i++) phase_in[i] = {exp_addr(i), 24'h5A5A5A};
        phase_in[5] = 32'h4000_0000;
        test_reset();
        test_single_voice();
        test_full_scale();
        test_gating();
        test_overrun();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
